muldiv_ctrl: RTL
================

# muldiv_ctrl

Sequencing controller for the MIPS multiply/divide path. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO requests from the decode stage and owns the architectural HI/LO registers. It launches the shared iterative ALU divider and waits for its done flag, and it stalls MFHI/MFLO reads until the result lands. It sits between the execute stage and the ALU divider, replacing ad-hoc start/reset pulsing from the core.

## Interface

Parameters:
- `DIV_TIMEOUT`, default 40: maximum cycles spent in WAIT before aborting the divide.

Ports:
- `clk`, in, 1: single clock; all state updates on its rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `req_valid`, in, 1: request present this cycle.
- `req_op`, in, 3: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6–7 ignored.
- `req_a`, in, 32: rs operand (dividend / multiplicand / MTHI-MTLO data).
- `req_b`, in, 32: rt operand (divisor / multiplier).
- `req_ready`, out, 1: high only in IDLE.
- `rd_req`, in, 1: core is executing MFHI/MFLO.
- `rd_sel`, in, 1: 0 selects LO, 1 selects HI.
- `rd_data`, out, 32: combinational HI or LO.
- `rd_stall`, out, 1: equals `rd_req & ~req_ready`.
- `div_start`, out, 1: one-cycle pulse that resets and loads the divider (drives the ALU `divrst`).
- `div_signed`, out, 1: registered; 1 for DIV, 0 for DIVU.
- `div_a`, out, 32: registered dividend.
- `div_b`, out, 32: registered divisor.
- `div_done`, in, 1: level; divider holds it until the next `div_start`.
- `div_quot`, in, 32: quotient, valid while `div_done`.
- `div_rem`, in, 32: remainder, valid while `div_done`.
- `div_err`, out, 1: sticky timeout flag, cleared only by `rst`.

## Operation

- States: IDLE, START, WAIT, WRITE.
- A request is accepted when `req_valid & req_ready`. Invalid opcodes are dropped and the state stays IDLE.
- MULT/MULTU: the 64-bit product is formed internally, signed or unsigned. {HI,LO} is written at the accepting edge and the state stays IDLE.
- MTHI/MTLO: `req_a` is written to HI or LO at the accepting edge and the state stays IDLE.
- DIV/DIVU: `div_a`, `div_b` and `div_signed` latch at the accepting edge. Transition IDLE→START.
- START: `div_start`=1 for exactly this cycle. Transition →WAIT.
- WAIT: `div_done` is ignored during the first cycle in WAIT, which covers stale done from a previous operation. After that, `div_done`=1 → WRITE.
- WAIT timeout: a cycle counter reaching `DIV_TIMEOUT` sets `div_err` and goes →IDLE. HI/LO are left unchanged.
- WRITE: LO←`div_quot`, HI←`div_rem`. Transition →IDLE.
- Divide arithmetic and sign rules are the divider's. The controller never alters quotient or remainder.
- Simultaneous `rd_req` on the accepting edge of a MULT/MT*: `rd_data` shows the old value that cycle. Hazard forwarding is the core's job.

## Timing

- Reset values: state IDLE, HI=0, LO=0, `div_start`=0, `div_signed`=0, `div_a`=`div_b`=0, `div_err`=0, counter 0. `req_ready`=1 in the cycle after reset.
- Divide cost: accept (cycle 0), START (1), WAIT (2..N), WRITE (N+1), IDLE (N+2). HI/LO are visible from cycle N+2.
- MULT/MT* latency: one edge. HI/LO are visible the next cycle, and back-to-back requests are allowed.
- `rd_stall` is high in START, WAIT and WRITE whenever `rd_req`=1. It falls in the first cycle `rd_data` holds the new result.
- `rst` in any state: the next cycle is IDLE with all reset values. `div_start` is not pulsed.

## Configuration

- `MULDIV_DIV0_BYPASS_EN` defined: a DIV/DIVU with `req_b`==0 skips the divider entirely. At the accepting edge LO←32'hFFFFFFFF and HI←`req_a`, the state stays IDLE, and `div_start` is not pulsed.
- `MULDIV_DIV0_BYPASS_EN` undefined: divide-by-zero runs the normal START/WAIT/WRITE sequence and takes whatever the divider returns.

## Structure

- Shared package `muldiv_pkg`: the `req_op` enum (`OP_MULT`…`OP_MTLO`), the state enum, and the width constant `W=32`.
- One sub-module, `hilo_regs`: HI/LO storage with separate write enables and the `rd_sel` read mux.

## Test plan

- DIVU 5/2 with a divider model returning done after 34 cycles → LO=2, HI=1. `rd_stall` stays high until LO is readable, and `req_ready` returns at cycle N+2.
- DIV 0xFFFFFFF9 (−7) / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF, `div_signed`=1, and `div_start` high for exactly one cycle.
- MULT 0xFFFFFFFE × 3 → HI=0xFFFFFFFF, LO=0xFFFFFFFA. MULTU with the same operands → HI=0x00000002, LO=0xFFFFFFFA. Issue them back-to-back with no stall.
- `rst` asserted in WAIT → next cycle IDLE, HI=LO=0. A later `div_done` pulse causes no write.
- Divider never asserts done, `DIV_TIMEOUT`=40 → `div_err`=1 after 40 WAIT cycles, HI/LO unchanged, `req_ready`=1.
- DIVU 9/0 → with `MULDIV_DIV0_BYPASS_EN`: LO=0xFFFFFFFF, HI=9 after one edge and no `div_start`. Without it: the full sequence runs with `div_start` pulsed.

Source files
------------

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types and constants for the multiply/divide controller.
// Holds the request opcode encoding, the controller state encoding and the
// datapath width.
package muldiv_pkg;

    localparam int W = 32;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_WRITE = 2'd3
    } state_e;

endpackage

// File: rtl/muldiv_hilo_regs.sv
// hilo_regs: architectural HI/LO storage with independent write enables
// and a combinational read mux (rd_sel: 0 = LO, 1 = HI).
module hilo_regs
    import muldiv_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         hi_we,
    input  logic [W-1:0] hi_wd,
    input  logic         lo_we,
    input  logic [W-1:0] lo_wd,
    input  logic         rd_sel,
    output logic [W-1:0] rd_data
);

    logic [W-1:0] hi_q, hi_d;
    logic [W-1:0] lo_q, lo_d;

    // Next-value selection: hold unless the matching write enable is set.
    always_comb begin
        hi_d = hi_we ? hi_wd : hi_q;
        lo_d = lo_we ? lo_wd : lo_q;
    end

    // HI/LO registers with synchronous reset to zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    assign rd_data = rd_sel ? hi_q : lo_q;

endmodule

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: sequences MULT/MULTU/DIV/DIVU/MTHI/MTLO requests, owns HI/LO,
// launches the external iterative divider and stalls MFHI/MFLO until results
// land.
// Optional build macro MULDIV_DIV0_BYPASS_EN: divide by zero is resolved at
// accept time (LO = all ones, HI = dividend) without starting the divider.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | ready for a request; MULT/MT* complete here in one edge
// ST_START | one-cycle div_start pulse, divider operands already latched
// ST_WAIT  | waiting for div_done (first cycle ignored), timeout counted
// ST_WRITE | quotient to LO, remainder to HI
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int DIV_TIMEOUT = 40
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    input  logic [2:0]   req_op,
    input  logic [W-1:0] req_a,
    input  logic [W-1:0] req_b,
    output logic         req_ready,
    input  logic         rd_req,
    input  logic         rd_sel,
    output logic [W-1:0] rd_data,
    output logic         rd_stall,
    output logic         div_start,
    output logic         div_signed,
    output logic [W-1:0] div_a,
    output logic [W-1:0] div_b,
    input  logic         div_done,
    input  logic [W-1:0] div_quot,
    input  logic [W-1:0] div_rem,
    output logic         div_err
);

    localparam int          CW      = $clog2(DIV_TIMEOUT + 1);
    localparam logic [CW-1:0] TO_LAST = CW'(DIV_TIMEOUT - 1);

    state_e        state_q, state_d;
    logic          div_signed_q, div_signed_d;
    logic [W-1:0]  div_a_q, div_a_d;
    logic [W-1:0]  div_b_q, div_b_d;
    logic          div_err_q, div_err_d;
    logic [CW-1:0] wait_cnt_q, wait_cnt_d;

    logic          hi_we, lo_we;
    logic [W-1:0]  hi_wd, lo_wd;
    logic [2*W-1:0] prod_s, prod_u;
    logic          div0_bypass;

`ifdef MULDIV_DIV0_BYPASS_EN
    assign div0_bypass = (req_b == '0);
`else
    assign div0_bypass = 1'b0;
`endif

    // Full-width products; operands widened first so the 64-bit result is exact.
    always_comb begin
        prod_s = $signed({{W{req_a[W-1]}}, req_a}) * $signed({{W{req_b[W-1]}}, req_b});
        prod_u = {{W{1'b0}}, req_a} * {{W{1'b0}}, req_b};
    end

    // Next-state, divider operand latching and HI/LO write selection.
    always_comb begin
        state_d      = state_q;
        div_signed_d = div_signed_q;
        div_a_d      = div_a_q;
        div_b_d      = div_b_q;
        div_err_d    = div_err_q;
        wait_cnt_d   = wait_cnt_q;
        hi_we        = 1'b0;
        lo_we        = 1'b0;
        hi_wd        = '0;
        lo_wd        = '0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    case (req_op)
                        OP_MULT: begin
                            hi_we          = 1'b1;
                            lo_we          = 1'b1;
                            {hi_wd, lo_wd} = prod_s;
                        end
                        OP_MULTU: begin
                            hi_we          = 1'b1;
                            lo_we          = 1'b1;
                            {hi_wd, lo_wd} = prod_u;
                        end
                        OP_DIV, OP_DIVU: begin
                            if (div0_bypass) begin
                                hi_we = 1'b1;
                                lo_we = 1'b1;
                                hi_wd = req_a;
                                lo_wd = '1;
                            end else begin
                                div_a_d      = req_a;
                                div_b_d      = req_b;
                                div_signed_d = (req_op == OP_DIV);
                                state_d      = ST_START;
                            end
                        end
                        OP_MTHI: begin
                            hi_we = 1'b1;
                            hi_wd = req_a;
                        end
                        OP_MTLO: begin
                            lo_we = 1'b1;
                            lo_wd = req_a;
                        end
                        default: ;
                    endcase
                end
            end
            ST_START: begin
                wait_cnt_d = '0;
                state_d    = ST_WAIT;
            end
            ST_WAIT: begin
                // Count zero marks the first WAIT cycle, where done may be stale.
                if (div_done && (wait_cnt_q != '0)) begin
                    wait_cnt_d = '0;
                    state_d    = ST_WRITE;
                end else if (wait_cnt_q == TO_LAST) begin
                    wait_cnt_d = '0;
                    div_err_d  = 1'b1;
                    state_d    = ST_IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + CW'(1);
                end
            end
            ST_WRITE: begin
                hi_we   = 1'b1;
                lo_we   = 1'b1;
                hi_wd   = div_rem;
                lo_wd   = div_quot;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Controller state and divider interface registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            div_signed_q <= 1'b0;
            div_a_q      <= '0;
            div_b_q      <= '0;
            div_err_q    <= 1'b0;
            wait_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            div_signed_q <= div_signed_d;
            div_a_q      <= div_a_d;
            div_b_q      <= div_b_d;
            div_err_q    <= div_err_d;
            wait_cnt_q   <= wait_cnt_d;
        end
    end

    hilo_regs u_hilo (
        .clk     (clk),
        .rst     (rst),
        .hi_we   (hi_we),
        .hi_wd   (hi_wd),
        .lo_we   (lo_we),
        .lo_wd   (lo_wd),
        .rd_sel  (rd_sel),
        .rd_data (rd_data)
    );

    assign req_ready  = (state_q == ST_IDLE);
    assign rd_stall   = rd_req & ~req_ready;
    assign div_start  = (state_q == ST_START);
    assign div_signed = div_signed_q;
    assign div_a      = div_a_q;
    assign div_b      = div_b_q;
    assign div_err    = div_err_q;

endmodule
